// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Safety stage behind the traffic light controller. It decodes the four 4-bit
// approach codes into registered one-hot {red,yellow,green} lamp drives.
// Every cycle it checks for conflicting or illegal codes. If a violation
// persists for FAULT_PERSIST cycles, the block latches a fail-safe fault mode.
// In fault mode every approach flashes red until a qualified clear or a reset.
//
// Interface note: there is no valid/ready handshake. The light codes are
// sampled on every rising edge. All outputs are registered and reflect the
// inputs of the previous cycle (latency 1).
//
// The FSM state is kept in state_q (type state_e) so that checkers can bind to
// it. The fault output is a registered decode of that state.
module traffic_conflict_monitor #(
    parameter int FLASH_HALF    = 4,
    parameter int FAULT_PERSIST = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] north,
    input  logic [3:0] east,
    input  logic [3:0] south,
    input  logic [3:0] west,
    input  logic       fault_clear,
    output logic [2:0] lamp_n,
    output logic [2:0] lamp_e,
    output logic [2:0] lamp_s,
    output logic [2:0] lamp_w,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam int PW = (FAULT_PERSIST > 1) ? $clog2(FAULT_PERSIST) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    // One extra bit so the incremented persistence count can represent FAULT_PERSIST itself
    localparam logic [PW:0]   PERSIST_LIM = (PW + 1)'(FAULT_PERSIST);
    localparam logic [FW-1:0] FLASH_LAST  = FW'(FLASH_HALF - 1);

    localparam logic [3:0] CODE_GREEN  = 4'd0;
    localparam logic [3:0] CODE_YELLOW = 4'd1;
    localparam logic [3:0] CODE_RED    = 4'd2;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] persist_q, persist_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_off_q, flash_off_d;   // 0 = red-on phase, 1 = dark phase
    logic [1:0]    cause_q, cause_d;
    logic [2:0]    lamp_n_q, lamp_n_d;
    logic [2:0]    lamp_e_q, lamp_e_d;
    logic [2:0]    lamp_s_q, lamp_s_d;
    logic [2:0]    lamp_w_q, lamp_w_d;

    logic [3:0]    go;          // approach shows a valid non-red code
    logic [3:0]    bad;         // approach shows an undefined code
    logic          conflict;
    logic          invalid;
    logic          violation;
    logic [PW:0]   persist_inc;

    // Map a light code to its lamp drive. Invalid codes fall back to red.
    // The violation logic keeps such a cycle from ever being decoded.
    function automatic logic [2:0] decode(input logic [3:0] code);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        case (code)
            CODE_GREEN:  lamp = LAMP_GREEN;
            CODE_YELLOW: lamp = LAMP_YELLOW;
            CODE_RED:    lamp = LAMP_RED;
            default:     lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    // Classify each approach and derive this cycle's violation flags
    always_comb begin
        go[0]  = (north == CODE_GREEN) || (north == CODE_YELLOW);
        go[1]  = (east  == CODE_GREEN) || (east  == CODE_YELLOW);
        go[2]  = (south == CODE_GREEN) || (south == CODE_YELLOW);
        go[3]  = (west  == CODE_GREEN) || (west  == CODE_YELLOW);
        bad[0] = north > CODE_RED;
        bad[1] = east  > CODE_RED;
        bad[2] = south > CODE_RED;
        bad[3] = west  > CODE_RED;
        // Conflict when more than one go bit is set: clearing the lowest set bit leaves a remainder
        conflict    = (go & (go - 4'd1)) != 4'd0;
        invalid     = |bad;
        violation   = conflict || invalid;
        persist_inc = {1'b0, persist_q} + {{PW{1'b0}}, 1'b1};
    end

    // Next-state, counter and lamp logic for the RUN/FAULT controller
    always_comb begin
        state_d     = state_q;
        persist_d   = persist_q;
        flash_cnt_d = flash_cnt_q;
        flash_off_d = flash_off_q;
        cause_d     = cause_q;
        lamp_n_d    = LAMP_RED;
        lamp_e_d    = LAMP_RED;
        lamp_s_d    = LAMP_RED;
        lamp_w_d    = LAMP_RED;

        case (state_q)
            ST_RUN: begin
                if (violation) begin
                    if (persist_inc >= PERSIST_LIM) begin
                        // Latch the fault; the first fault cycle is a red-on cycle
                        state_d     = ST_FAULT;
                        cause_d     = {invalid, conflict};
                        persist_d   = '0;
                        flash_cnt_d = '0;
                        flash_off_d = 1'b0;
                    end else begin
                        persist_d = persist_inc[PW-1:0];
                    end
                end else begin
                    persist_d = '0;
                    lamp_n_d  = decode(north);
                    lamp_e_d  = decode(east);
                    lamp_s_d  = decode(south);
                    lamp_w_d  = decode(west);
                end
            end

            ST_FAULT: begin
                if (fault_clear && !violation) begin
                    // Leave with all lamps red; decoding resumes one cycle later
                    state_d     = ST_RUN;
                    cause_d     = 2'b00;
                    persist_d   = '0;
                    flash_cnt_d = '0;
                    flash_off_d = 1'b0;
                end else begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = '0;
                        flash_off_d = !flash_off_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + {{(FW-1){1'b0}}, 1'b1};
                    end
                    if (flash_off_d) begin
                        lamp_n_d = LAMP_OFF;
                        lamp_e_d = LAMP_OFF;
                        lamp_s_d = LAMP_OFF;
                        lamp_w_d = LAMP_OFF;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers; reset overrides every other condition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            persist_q   <= '0;
            flash_cnt_q <= '0;
            flash_off_q <= 1'b0;
            cause_q     <= 2'b00;
            lamp_n_q    <= LAMP_RED;
            lamp_e_q    <= LAMP_RED;
            lamp_s_q    <= LAMP_RED;
            lamp_w_q    <= LAMP_RED;
        end else begin
            state_q     <= state_d;
            persist_q   <= persist_d;
            flash_cnt_q <= flash_cnt_d;
            flash_off_q <= flash_off_d;
            cause_q     <= cause_d;
            lamp_n_q    <= lamp_n_d;
            lamp_e_q    <= lamp_e_d;
            lamp_s_q    <= lamp_s_d;
            lamp_w_q    <= lamp_w_d;
        end
    end

    assign lamp_n      = lamp_n_q;
    assign lamp_e      = lamp_e_q;
    assign lamp_s      = lamp_s_q;
    assign lamp_w      = lamp_w_q;
    assign fault       = (state_q == ST_FAULT);
    assign fault_cause = cause_q;

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
Downstream safety stage of the traffic light controller. Registers the four per-approach 4-bit light codes and decodes them into one-hot lamp drives. It also checks every cycle for conflicting or illegal codes. A violation that persists latches a fail-safe fault mode, in which all approaches flash red until a qualified clear or reset.

Parameters:
FLASH_HALF, 4, cycles per half-period of the fail-safe red flash (>=1)
FAULT_PERSIST, 2, consecutive violating cycles required to latch a fault (>=1; 1 = latch on first violation)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
north  in  4  light code, north approach
east  in  4  light code, east approach
south  in  4  light code, south approach
west  in  4  light code, west approach
fault_clear  in  1  request to leave fault mode (level-sampled)
lamp_n  out  3  {red,yellow,green} one-hot drive, north
lamp_e  out  3  same, east
lamp_s  out  3  same, east-south order: south
lamp_w  out  3  same, west
fault  out  1  high while in fault mode
fault_cause  out  2  bit0 = conflict, bit1 = invalid code; latched at fault entry

Behaviour:
- One clock, synchronous active-high reset; all outputs registered.
- Code map: 4'd0 GREEN -> 3'b001; 4'd1 YELLOW -> 3'b010; 4'd2 RED -> 3'b100; any other value is invalid.
- Violation in a cycle = conflict OR invalid.
  - conflict: two or more approaches carry a valid non-RED code.
  - invalid: any approach carries a code > 2.
- Reset: state RUN; all lamps 3'b100; fault=0; fault_cause=0; persistence counter 0; flash counter 0.
  - Reset overrides everything, including mid-flash and a simultaneous fault_clear.
- State RUN:
  - Clean cycle: lamps take the decoded inputs at the next edge (latency 1); persistence counter clears to 0.
  - Violating cycle: all lamps = 3'b100 at the next edge; persistence counter increments, saturating.
  - When the increment would reach FAULT_PERSIST, the same edge moves to FAULT: fault<=1; fault_cause<={invalid,conflict} of that cycle; lamps<=3'b100; flash counter<=0.
  - fault_clear is ignored in RUN.
- State FAULT:
  - Inputs are not decoded.
  - All four lamps show 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating. The first FAULT cycle is the red-on phase.
  - Flash counter wraps at FLASH_HALF-1 and toggles the phase on wrap.
  - fault_clear=1 in a clean cycle: next edge goes to RUN with fault=0, fault_cause=0, all lamps 3'b100, persistence counter 0. Normal decode resumes the cycle after.
  - fault_clear=1 in a violating cycle is ignored; FAULT and the flash pattern continue uninterrupted.
  - fault_cause holds its value for the whole fault period; new violations do not update it.
- Counter widths: clog2 of the respective parameter, minimum 1 bit.

Test Plan:
1. Reset, then apply N=0, E/S/W=2 -> one edge later lamp_n=001, others 100, fault=0. Step N=1 then N=2,E=0 -> lamps track each step with 1-cycle latency.
2. FAULT_PERSIST=2: apply N=0,E=0 for one cycle, then clean -> lamps all 100 for one cycle, normal decode resumes, fault stays 0.
3. N=0,E=1 held 2 cycles -> fault=1 and fault_cause=01 after the 2nd edge. Lamps all 100 for 4 cycles, 000 for 4 cycles, repeating with FLASH_HALF=4.
4. Hold west=4'd7 with the others RED for 2 cycles -> fault=1, fault_cause=10. Apply N=0,E=0 plus west=4'd9 at the latching cycle instead -> fault_cause=11.
5. In FAULT, assert fault_clear while the conflict persists -> no change. Remove the conflict with fault_clear still high -> next edge fault=0, lamps 100, then normal decode.
6. Assert rst during the flash-off phase with fault_clear=1 -> next edge lamps 100, fault=0, cause=00, state RUN.
